layer_tile_sequencer: RTL and testbench

//  Layer-level control sequencer for the TinyYOLO compute unit. It tiles a layer whose out_channels exceeds
//  NUM_FILTERS into ceil(out_channels/NUM_FILTERS) passes, and runs a parameter-load handshake before each pass.
//  It tracks col/row/channel of every accepted pixel and drives weight/bias BRAM read addresses.
//  It also emits per-pixel tags (first/last channel, stride keep, output tlast, active lane count).
//  It sits between the AXI-Lite scalar registers, parameter_loader, the pixel serializer and the accumulator/packer.

---
 rtl/layer_tile_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_layer_tile_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/layer_tile_sequencer.sv
// Layer tile sequencer: splits a layer into ceil(out_channels/NUM_FILTERS) passes with a parameter-load handshake per pass.
// Latency: tag outputs are combinational on the accepted pixel; done pulses 2 cycles after the last pixel or after start on a bad config.
// Backpressure: counters advance only on pixel_valid in COMPUTE; LOAD waits indefinitely for load_done.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   start + img_width/img_height/in_channels/out_channels/stride    layer configuration, latched in IDLE on start
//   load_en / load_done             parameter_loader handshake (registered request, one-cycle completion pulse)
//   pixel_valid                     one pixel accepted this cycle, ordered col, row, ch
//   weight_addr, bias_addr          weight/bias BRAM read addresses (current ch / current tile)
//   tile_idx, active_lanes          current pass and its number of live filter lanes
//   pix_col, pix_row, first_ch, last_ch, out_keep, out_last   per-pixel tags
//   busy, done, err                 layer active / completion pulse / configuration error (valid with done)
module layer_tile_sequencer #(
    parameter int NUM_FILTERS = 64,
    parameter int DIM_W       = 12,
    parameter int CH_W        = 12,
    parameter int W_ADDR_W    = 9,
    parameter int TILE_W      = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [DIM_W-1:0]    img_width,
    input  logic [DIM_W-1:0]    img_height,
    input  logic [CH_W-1:0]     in_channels,
    input  logic [CH_W-1:0]     out_channels,
    input  logic [1:0]          stride,
    output logic                load_en,
    input  logic                load_done,
    input  logic                pixel_valid,
    output logic [W_ADDR_W-1:0] weight_addr,
    output logic [TILE_W-1:0]   bias_addr,
    output logic [TILE_W-1:0]   tile_idx,
    output logic [DIM_W-1:0]    pix_col,
    output logic [DIM_W-1:0]    pix_row,
    output logic                first_ch,
    output logic                last_ch,
    output logic                out_keep,
    output logic                out_last,
    output logic [7:0]          active_lanes,
    output logic                busy,
    output logic                done,
    output logic                err
);
    // One extra bit so tile-count and lane arithmetic cannot overflow.
    localparam int CW = CH_W + 1;
    localparam int TW = TILE_W + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_LOAD, S_COMPUTE, S_TILE_END, S_FINISH
    } state_t;

    state_t state, state_nx;

    logic [DIM_W-1:0]  width_r, height_r;
    logic [CH_W-1:0]   in_ch_r, out_ch_r;
    logic [1:0]        stride_r;
    logic [DIM_W-1:0]  col_r, row_r;
    logic [CH_W-1:0]   ch_r;
    logic [TILE_W-1:0] tile_r;
    logic [TW-1:0]     num_tiles_r;
    logic              err_r;

    logic [CW-1:0]     tiles_calc;
    logic [CW-1:0]     lanes_left;
    logic [TW-1:0]     tile_inc;
    logic              cfg_bad;
    logic              acc, col_end, row_end, ch_end, pass_end, s2;
    logic [DIM_W-1:0]  last_kcol, last_krow;

    assign tiles_calc = (CW'(out_ch_r) + CW'(NUM_FILTERS - 1)) / CW'(NUM_FILTERS);
    assign lanes_left = CW'(out_ch_r) - CW'(tile_r) * CW'(NUM_FILTERS);
    assign tile_inc   = TW'(tile_r) + TW'(1);

    assign cfg_bad = (width_r == '0) || (height_r == '0) || (in_ch_r == '0) ||
                     (CW'(in_ch_r) > CW'(2**W_ADDR_W)) || (out_ch_r == '0) ||
                     ((stride_r != 2'd1) && (stride_r != 2'd2)) ||
                     (tiles_calc > CW'(2**TILE_W));

    assign acc      = pixel_valid && (state == S_COMPUTE);
    assign col_end  = (col_r == width_r - DIM_W'(1));
    assign row_end  = (row_r == height_r - DIM_W'(1));
    assign ch_end   = (ch_r == in_ch_r - CH_W'(1));
    assign pass_end = acc && col_end && row_end && ch_end;

    // Last kept coordinate: with stride 2 it is the largest even index, i.e. W-2 when W is even.
    assign s2        = (stride_r == 2'd2);
    assign last_kcol = (s2 && !width_r[0])  ? width_r - DIM_W'(2)  : width_r - DIM_W'(1);
    assign last_krow = (s2 && !height_r[0]) ? height_r - DIM_W'(2) : height_r - DIM_W'(1);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:     if (start) state_nx = S_CHECK;
            S_CHECK:    state_nx = cfg_bad ? S_FINISH : S_LOAD;
            S_LOAD:     if (load_done) state_nx = S_COMPUTE;
            S_COMPUTE:  if (pass_end) state_nx = S_TILE_END;
            S_TILE_END: state_nx = (tile_inc < num_tiles_r) ? S_LOAD : S_FINISH;
            S_FINISH:   state_nx = S_IDLE;
            default:    state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            width_r     <= '0;
            height_r    <= '0;
            in_ch_r     <= '0;
            out_ch_r    <= '0;
            stride_r    <= '0;
            col_r       <= '0;
            row_r       <= '0;
            ch_r        <= '0;
            tile_r      <= '0;
            num_tiles_r <= '0;
            err_r       <= 1'b0;
            load_en     <= 1'b0;
        end else begin
            // Registered request: rises on the same edge that enters LOAD, drops on the edge that leaves it.
            load_en <= (state_nx == S_LOAD);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        width_r  <= img_width;
                        height_r <= img_height;
                        in_ch_r  <= in_channels;
                        out_ch_r <= out_channels;
                        stride_r <= stride;
                        err_r    <= 1'b0;
                    end
                end
                S_CHECK: begin
                    err_r       <= cfg_bad;
                    num_tiles_r <= tiles_calc[TW-1:0];
                    tile_r      <= '0;
                    col_r       <= '0;
                    row_r       <= '0;
                    ch_r        <= '0;
                end
                S_COMPUTE: begin
                    if (acc) begin
                        if (!col_end) begin
                            col_r <= col_r + DIM_W'(1);
                        end else begin
                            col_r <= '0;
                            if (!row_end) begin
                                row_r <= row_r + DIM_W'(1);
                            end else begin
                                row_r <= '0;
                                ch_r  <= ch_end ? '0 : ch_r + CH_W'(1);
                            end
                        end
                    end
                end
                S_TILE_END: tile_r <= tile_r + TILE_W'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        active_lanes = 8'd0;
        if ((state == S_LOAD) || (state == S_COMPUTE) || (state == S_TILE_END))
            active_lanes = (lanes_left >= CW'(NUM_FILTERS)) ? 8'(NUM_FILTERS) : lanes_left[7:0];
    end

    assign pix_col     = acc ? col_r : '0;
    assign pix_row     = acc ? row_r : '0;
    assign first_ch    = acc && (ch_r == '0);
    assign last_ch     = acc && ch_end;
    assign out_keep    = last_ch && (!s2 || !col_r[0]) && (!s2 || !row_r[0]);
    assign out_last    = out_keep && (col_r == last_kcol) && (row_r == last_krow);
    assign weight_addr = ch_r[W_ADDR_W-1:0];
    assign bias_addr   = tile_r;
    assign tile_idx    = tile_r;
    assign busy        = (state != S_IDLE);
    assign done        = (state == S_FINISH);
    assign err         = done && err_r;

endmodule

// File: tb/tb_layer_tile_sequencer.sv
// Directed bench for layer_tile_sequencer: drives whole layers pixel by pixel, checks every tag against
// a coordinate model, and checks handshake/lane/done timing against hand-computed values.
module tb_layer_tile_sequencer;
    localparam int NF = 64;

    logic        clk = 1'b0;
    logic        rst, start, load_done, pixel_valid;
    logic [11:0] img_width, img_height, in_channels, out_channels;
    logic [1:0]  stride;
    logic        load_en, first_ch, last_ch, out_keep, out_last, busy, done, err;
    logic [8:0]  weight_addr;
    logic [5:0]  bias_addr, tile_idx;
    logic [11:0] pix_col, pix_row;
    logic [7:0]  active_lanes;

    always #5 clk = ~clk;

    layer_tile_sequencer dut (
        .clk(clk), .rst(rst), .start(start),
        .img_width(img_width), .img_height(img_height),
        .in_channels(in_channels), .out_channels(out_channels), .stride(stride),
        .load_en(load_en), .load_done(load_done), .pixel_valid(pixel_valid),
        .weight_addr(weight_addr), .bias_addr(bias_addr), .tile_idx(tile_idx),
        .pix_col(pix_col), .pix_row(pix_row), .first_ch(first_ch), .last_ch(last_ch),
        .out_keep(out_keep), .out_last(out_last), .active_lanes(active_lanes),
        .busy(busy), .done(done), .err(err)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Event monitor, sampled on the falling edge.
    logic mon_clr = 1'b0;
    logic load_en_d = 1'b0;
    int mon_loads = 0, mon_keeps = 0, mon_lasts = 0, mon_dones = 0, mon_lcol = -1, mon_lrow = -1;

    always @(negedge clk) begin
        if (mon_clr) begin
            mon_loads = 0; mon_keeps = 0; mon_lasts = 0; mon_dones = 0;
            mon_lcol = -1; mon_lrow = -1; load_en_d = 1'b0;
        end else begin
            if (load_en && !load_en_d) mon_loads++;
            load_en_d = load_en;
            if (out_keep) mon_keeps++;
            if (out_last) begin mon_lasts++; mon_lcol = pix_col; mon_lrow = pix_row; end
            if (done) mon_dones++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_mon();
        mon_clr = 1'b1;
        tick();
        mon_clr = 1'b0;
    endtask

    task automatic drive_start(input int w, input int h, input int c, input int oc, input int s);
        img_width = 12'(w); img_height = 12'(h); in_channels = 12'(c);
        out_channels = 12'(oc); stride = 2'(s); start = 1'b1;
        tick();
        // Scramble the config inputs: the layer must run on the latched copy.
        start = 1'b0; img_width = 12'd7; img_height = 12'd9; in_channels = 12'd3;
        out_channels = 12'd1; stride = 2'd3;
    endtask

    task automatic run_layer(input string nm, input int w, input int h, input int c, input int oc,
                             input int s, input bit gap, input int ldly, input int abort_tile,
                             input int exp_loads, input int exp_keeps, input int exp_lc, input int exp_lr);
        int tiles, errs, to, lc, lr, lanes;
        bit kp;
        clr_mon();
        drive_start(w, h, c, oc, s);
        tiles = (oc + NF - 1) / NF;
        lc = ((w - 1) / s) * s;
        lr = ((h - 1) / s) * s;
        errs = 0;
        for (int t = 0; t < tiles; t++) begin
            to = 0;
            @(negedge clk);
            while (load_en !== 1'b1 && to < 100) begin to++; @(negedge clk); end
            check({nm, " load_en"}, load_en, 1);
            if (load_en !== 1'b1) begin tick(); return; end
            lanes = (oc - t * NF > NF) ? NF : oc - t * NF;
            check({nm, " active_lanes"}, active_lanes, lanes);
            check({nm, " bias_addr"}, bias_addr, t);
            check({nm, " tile_idx"}, tile_idx, t);
            tick();
            repeat (ldly) tick();
            load_done = 1'b1;
            tick();
            load_done = 1'b0;
            for (int ch = 0; ch < c; ch++)
                for (int row = 0; row < h; row++)
                    for (int col = 0; col < w; col++) begin
                        if (t == abort_tile && ch == 0 && row == 0 && col == 2) begin
                            rst = 1'b1;
                            tick();
                            rst = 1'b0;
                            @(negedge clk);
                            check({nm, " abort busy"}, busy, 0);
                            check({nm, " abort load_en"}, load_en, 0);
                            tick();
                            repeat (4) tick();
                            check({nm, " abort done count"}, mon_dones, 0);
                            return;
                        end
                        // Idle cycles carry stray start/load_done, which the DUT must ignore.
                        for (int g = 0; g < 3 && gap && $urandom_range(0, 1) == 0; g++) begin
                            start = 1'b1; load_done = 1'b1;
                            tick();
                        end
                        start = 1'b0; load_done = 1'b0; pixel_valid = 1'b1;
                        @(negedge clk);
                        kp = (ch == c - 1) && (col % s == 0) && (row % s == 0);
                        if (pix_col !== 12'(col) || pix_row !== 12'(row) || first_ch !== (ch == 0) ||
                            last_ch !== (ch == c - 1) || weight_addr !== 9'(ch) || bias_addr !== 6'(t) ||
                            out_keep !== kp || out_last !== (kp && col == lc && row == lr))
                            errs++;
                        tick();
                        pixel_valid = 1'b0;
                    end
        end
        @(negedge clk);
        check({nm, " done early"}, done, 0);
        tick();
        @(negedge clk);
        check({nm, " done"}, done, 1);
        check({nm, " err"}, err, 0);
        tick();
        @(negedge clk);
        check({nm, " idle busy"}, busy, 0);
        check({nm, " done width"}, done, 0);
        tick();
        check({nm, " tag errors"}, errs, 0);
        check({nm, " loads"}, mon_loads, exp_loads);
        check({nm, " keeps"}, mon_keeps, exp_keeps);
        check({nm, " lasts"}, mon_lasts, exp_loads);
        check({nm, " last col"}, mon_lcol, exp_lc);
        check({nm, " last row"}, mon_lrow, exp_lr);
        check({nm, " done count"}, mon_dones, 1);
    endtask

    task automatic run_err(input string nm, input int w, input int h, input int c, input int oc, input int s);
        clr_mon();
        drive_start(w, h, c, oc, s);
        @(negedge clk);
        check({nm, " done in check"}, done, 0);
        tick();
        @(negedge clk);
        check({nm, " done"}, done, 1);
        check({nm, " err"}, err, 1);
        tick();
        @(negedge clk);
        check({nm, " idle busy"}, busy, 0);
        check({nm, " err cleared"}, err, 0);
        tick();
        repeat (3) tick();
        check({nm, " loads"}, mon_loads, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; load_done = 1'b0; pixel_valid = 1'b1;
        img_width = '0; img_height = '0; in_channels = '0; out_channels = '0; stride = '0;
        tick();
        tick();
        rst = 1'b0;
        load_done = 1'b1;
        @(negedge clk);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst err", err, 0);
        check("rst load_en", load_en, 0);
        check("rst tile_idx", tile_idx, 0);
        check("rst active_lanes", active_lanes, 0);
        check("idle out_keep", out_keep, 0);
        check("idle first_ch", first_ch, 0);
        tick();
        @(negedge clk);
        check("idle ignores load_done", busy, 0);
        tick();
        pixel_valid = 1'b0; load_done = 1'b0;

        run_layer("c1 basic", 4, 4, 2, 64, 1, 1'b0, 0, -1, 1, 16, 3, 3);
        run_layer("c2 three tiles", 4, 2, 1, 130, 1, 1'b0, 0, -1, 3, 24, 3, 1);
        run_layer("c3 stride2", 5, 3, 1, 10, 2, 1'b0, 0, -1, 1, 6, 4, 2);
        run_layer("c3b stride2 even", 4, 4, 1, 64, 2, 1'b0, 0, -1, 1, 4, 2, 2);
        run_err("c4 stride3", 4, 4, 2, 64, 3);
        run_err("c4 in_ch0", 4, 4, 0, 64, 1);
        run_err("c4 in_ch513", 4, 4, 513, 64, 1);
        run_err("c4 width0", 0, 4, 2, 64, 1);
        run_err("c4 out0", 4, 4, 2, 0, 1);
        run_layer("c5 gapped", 4, 4, 2, 64, 1, 1'b1, 20, -1, 1, 16, 3, 3);
        run_layer("c6 abort", 4, 2, 1, 130, 1, 1'b0, 0, 1, 0, 0, 0, 0);
        run_layer("c6 rerun", 4, 4, 2, 64, 1, 1'b0, 0, -1, 1, 16, 3, 3);
        run_layer("max in_ch", 1, 1, 512, 1, 2, 1'b0, 0, -1, 1, 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
